// File: rtl/pong_pkg.sv
// Shared Pong encodings: game states, winner codes and switch bit positions.
// The paddle mover and ball logic import this package too.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam int SW_R_UP = 0;
    localparam int SW_R_DN = 1;
    localparam int SW_L_UP = 2;
    localparam int SW_L_DN = 3;

    // Up and down pressed together on one paddle cancel to "no move".
    function automatic logic [3:0] gateSw(input logic [3:0] sw);
        logic [3:0] g;
        g = sw;
        if (sw[SW_R_UP] && sw[SW_R_DN]) begin
            g[SW_R_UP] = 1'b0;
            g[SW_R_DN] = 1'b0;
        end
        if (sw[SW_L_UP] && sw[SW_L_DN]) begin
            g[SW_L_UP] = 1'b0;
            g[SW_L_DN] = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/frame_div.sv
// Frame-tick divider: emits a registered one-cycle step on every DIV-th enabled tick.
module frame_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic tick,
    output logic step
);
    localparam int DIV_EFF = (DIV < 1) ? 1 : DIV;
    localparam int W = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
    localparam logic [W-1:0] LAST = W'(DIV_EFF - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (en && tick) begin
                if (cnt == LAST) begin
                    cnt  <= '0;
                    step <= 1'b1;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/over FSM, score keeping and paddle move gating.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int MOVE_DIV     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [3:0] switches,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] paddle_sw,
    output logic       paddle_step,
    output logic       ball_run,
    output logic       ball_reset,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [2:0] state,
    output logic [1:0] winner
);
    localparam int SF = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
    localparam int PF = (POINT_FRAMES < 1) ? 1 : POINT_FRAMES;
    localparam int CW = $clog2(((SF > PF) ? SF : PF) + 1);
    localparam logic [CW-1:0] SF_LD = CW'(SF);
    localparam logic [CW-1:0] PF_LD = CW'(PF);
    localparam logic [3:0]    WIN   = 4'(WIN_SCORE);

    state_t        cur, nxt;
    logic [CW-1:0] frameCnt, cntNxt;
    logic [3:0]    scoreLNxt, scoreRNxt;
    logic [1:0]    winNxt;
    logic          startPrev, startEv, moveOk, divClr;

    assign startEv = start_btn && !startPrev;
    assign moveOk  = (cur == ST_SERVE) || (cur == ST_PLAY);
    assign divClr  = (nxt == ST_SERVE) && (cur != ST_SERVE);
    assign state   = cur;

    always_comb begin
        nxt       = cur;
        cntNxt    = frameCnt;
        scoreLNxt = score_left;
        scoreRNxt = score_right;
        winNxt    = winner;
        case (cur)
            ST_IDLE, ST_OVER: begin
                if (startEv) begin
                    nxt       = ST_SERVE;
                    cntNxt    = SF_LD;
                    scoreLNxt = '0;
                    scoreRNxt = '0;
                    winNxt    = WIN_NONE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (frameCnt <= CW'(1)) nxt = ST_PLAY;
                    else                    cntNxt = frameCnt - CW'(1);
                end
            end
            ST_PLAY: begin
                // A simultaneous double miss is a rally replay; a coincident tick only feeds the divider.
                if (miss_left && miss_right) begin
                    nxt    = ST_POINT;
                    cntNxt = PF_LD;
                end else if (miss_left) begin
                    scoreRNxt = (score_right >= WIN) ? WIN : score_right + 4'd1;
                    if (scoreRNxt == WIN) begin
                        winNxt = WIN_RIGHT;
                        nxt    = ST_OVER;
                    end else begin
                        nxt    = ST_POINT;
                        cntNxt = PF_LD;
                    end
                end else if (miss_right) begin
                    scoreLNxt = (score_left >= WIN) ? WIN : score_left + 4'd1;
                    if (scoreLNxt == WIN) begin
                        winNxt = WIN_LEFT;
                        nxt    = ST_OVER;
                    end else begin
                        nxt    = ST_POINT;
                        cntNxt = PF_LD;
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (frameCnt <= CW'(1)) begin
                        nxt    = ST_SERVE;
                        cntNxt = SF_LD;
                    end else begin
                        cntNxt = frameCnt - CW'(1);
                    end
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= ST_IDLE;
            frameCnt    <= '0;
            score_left  <= '0;
            score_right <= '0;
            winner      <= WIN_NONE;
            startPrev   <= 1'b0;
            paddle_sw   <= '0;
            ball_run    <= 1'b0;
            ball_reset  <= 1'b1;
        end else begin
            cur         <= nxt;
            frameCnt    <= cntNxt;
            score_left  <= scoreLNxt;
            score_right <= scoreRNxt;
            winner      <= winNxt;
            startPrev   <= start_btn;
            paddle_sw   <= moveOk ? gateSw(switches) : 4'b0000;
            // Ball flags follow the state being entered so they change together with it.
            ball_run    <= (nxt == ST_PLAY);
            ball_reset  <= (nxt != ST_PLAY);
        end
    end

    frame_div #(.DIV(MOVE_DIV)) uDiv (
        .clk  (clk),
        .rst  (rst),
        .clr  (divClr),
        .en   (moveOk),
        .tick (frame_tick),
        .step (paddle_step)
    );

endmodule
